// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO register pair and its iterative divider.
package hilo_div_unit_pkg;

    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivZero = 2'd1,
        DivRun  = 2'd2,
        DivDone = 2'd3
    } div_state_e;

    localparam logic DivStart    = 1'b1;
    localparam logic DivStop     = 1'b0;
    localparam logic WriteEnable = 1'b1;
    localparam logic RstEnable   = 1'b1;

    // Widest supported word; users cast it down to their WIDTH.
    localparam logic [63:0] ZeroWord = 64'h0;

endpackage

// File: rtl/hilo_div_unit_div_core.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
module div_core
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             result_valid_o,
    output logic             dz_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;

    logic             a_neg, b_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;

        a_neg   = signed_i & a_i[WIDTH-1];
        b_neg   = signed_i & b_i[WIDTH-1];
        // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
        shifted = {rem_q, quot_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr_q};

        unique case (state_q)
            DivIdle: begin
                if (start_i == DivStart && cancel_i == DivStop) begin
                    quot_d  = a_neg ? -a_i : a_i;
                    dvsr_d  = b_neg ? -b_i : b_i;
                    rem_d   = '0;
                    cnt_d   = '0;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dz_d    = (b_i == '0);
                    state_d = (b_i == '0) ? DivZero : DivRun;
                end
            end
            DivZero: begin
                state_d = cancel_i ? DivIdle : DivDone;
            end
            DivRun: begin
                if (cancel_i) begin
                    state_d = DivIdle;
                end else begin
                    if (trial[WIDTH]) begin
                        rem_d  = shifted[WIDTH-1:0];
                        quot_d = {quot_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_d  = trial[WIDTH-1:0];
                        quot_d = {quot_q[WIDTH-2:0], 1'b1};
                    end
                    if (cnt_q == LastCnt) begin
                        state_d = DivDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DivDone: begin
                state_d = DivIdle;
            end
            default: state_d = DivIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= DivIdle;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

    assign busy_o         = (state_q != DivIdle);
    assign result_valid_o = (state_q == DivDone);
    assign dz_o           = dz_q;
    assign quot_o         = q_neg_q ? -quot_q : quot_q;
    assign rem_o          = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO special registers with direct writes and an attached iterative divider.
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    input  logic             div_cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             core_valid;
    logic             core_dz;
    logic [WIDTH-1:0] core_quot;
    logic [WIDTH-1:0] core_rem;
    logic             div_commit;

    div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk            (clk),
        .rst            (rst),
        .start_i        (div_start),
        .signed_i       (div_signed),
        .a_i            (div_a),
        .b_i            (div_b),
        .cancel_i       (div_cancel),
        .busy_o         (busy),
        .result_valid_o (core_valid),
        .dz_o           (core_dz),
        .quot_o         (core_quot),
        .rem_o          (core_rem)
    );

    // Divider result overrides any direct write landing on the same edge.
    always_comb begin
        div_commit = core_valid & ~core_dz;
        hi_d       = hi_q;
        lo_d       = lo_q;
        if (hi_we == WriteEnable) hi_d = hi_i;
        if (lo_we == WriteEnable) lo_d = lo_i;
        if (div_commit) begin
            hi_d = core_rem;
            lo_d = core_quot;
        end
        done_d = core_valid;
        dz_d   = core_valid & core_dz;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            hi_q   <= WIDTH'(ZeroWord);
            lo_q   <= WIDTH'(ZeroWord);
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            dz_q   <= dz_d;
        end
    end

    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Randomised and directed checks of hilo_div_unit against an arithmetic reference model.
module tb_hilo_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         hi_we = 1'b0, lo_we = 1'b0;
    logic [W-1:0] hi_i = '0, lo_i = '0;
    logic         div_start = 1'b0, div_signed = 1'b0, div_cancel = 1'b0;
    logic [W-1:0] div_a = '0, div_b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi_o, lo_o;

    int unsigned  n_tests = 0;
    int unsigned  n_fail  = 0;
    logic [W-1:0] hi_m, lo_m;

    hilo_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .div_a       (div_a),
        .div_b       (div_b),
        .div_cancel  (div_cancel),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: 64-bit integer division, then truncation to W bits.
    task automatic ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = W'(sa / sb);
        r = W'(sa % sb);
    endtask

    task automatic direct_write(input logic [W-1:0] h, input logic [W-1:0] l);
        hi_we = 1'b1; lo_we = 1'b1; hi_i = h; lo_i = l;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        hi_m = h; lo_m = l;
    endtask

    // opt bits: [0] restart attempt while busy, [1] direct write mid-run, [2] direct write on commit edge
    task automatic run_div(input string tag, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2:0] opt);
        logic [W-1:0] eq, er;
        int unsigned  n, lat;
        logic         zero;
        zero = (b == '0);
        if (!zero) ref_div(s, a, b, eq, er);
        div_start = 1'b1; div_signed = s; div_a = a; div_b = b;
        tick();
        div_start = 1'b0; div_a = $urandom; div_b = $urandom; div_signed = ~s;
        check({tag, ".busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 100) begin
            if (opt[0] && n == 3) begin
                div_start = 1'b1; div_a = 32'd1000; div_b = 32'd1;
            end
            if (opt[1] && n == 5) begin
                hi_we = 1'b1; lo_we = 1'b1; hi_i = 32'h1234; lo_i = 32'h5678;
            end
            if (opt[2] && n == W) begin
                hi_we = 1'b1; lo_we = 1'b1; hi_i = 32'h55; lo_i = 32'h66;
            end
            tick();
            n++;
            div_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            if (opt[1] && n == 6) begin
                check({tag, ".mid_hi"}, 64'(hi_o), 64'h1234);
                check({tag, ".mid_lo"}, 64'(lo_o), 64'h5678);
                hi_m = 32'h1234; lo_m = 32'h5678;
            end
        end
        lat = zero ? 2 : W + 1;
        check({tag, ".latency"}, 64'(n), 64'(lat));
        check({tag, ".dz"}, 64'(div_by_zero), 64'(zero));
        if (!zero) begin
            hi_m = er; lo_m = eq;
        end
        check({tag, ".hi"}, 64'(hi_o), 64'(hi_m));
        check({tag, ".lo"}, 64'(lo_o), 64'(lo_m));
        tick();
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
        check({tag, ".dz_clear"}, 64'(div_by_zero), 64'd0);
    endtask

    task automatic cancel_div();
        bit seen_done;
        div_start = 1'b1; div_signed = 1'b0; div_a = 32'd1000; div_b = 32'd3;
        tick();
        div_start = 1'b0;
        repeat (10) tick();
        div_cancel = 1'b1;
        tick();
        div_cancel = 1'b0;
        check("cancel.busy", 64'(busy), 64'd0);
        seen_done = 1'b0;
        repeat (W + 5) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("cancel.no_done", 64'(seen_done), 64'd0);
        check("cancel.hi", 64'(hi_o), 64'(hi_m));
        check("cancel.lo", 64'(lo_o), 64'(lo_m));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        hi_m = '0; lo_m = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst.hi", 64'(hi_o), 64'h0);
        check("rst.lo", 64'(lo_o), 64'h0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.dz", 64'(div_by_zero), 64'd0);

        direct_write(32'h11, 32'h22);
        check("wr.hi", 64'(hi_o), 64'h11);
        check("wr.lo", 64'(lo_o), 64'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hi_m = '0; lo_m = '0;
        check("rst2.hi", 64'(hi_o), 64'h0);
        check("rst2.lo", 64'(lo_o), 64'h0);

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 3'b000);
        check("u100_7.q", 64'(lo_o), 64'd14);
        check("u100_7.r", 64'(hi_o), 64'd2);
        run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 3'b000);
        check("s-7_2.q", 64'(lo_o), 64'hFFFF_FFFD);
        check("s-7_2.r", 64'(hi_o), 64'hFFFF_FFFF);
        run_div("smin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3'b000);
        check("smin_m1.q", 64'(lo_o), 64'h8000_0000);
        check("smin_m1.r", 64'(hi_o), 64'h0);

        direct_write(32'hAA, 32'hBB);
        run_div("dz", 1'b0, 32'd77, 32'd0, 3'b000);
        check("dz.hi_kept", 64'(hi_o), 64'hAA);

        cancel_div();
        run_div("u9_3", 1'b0, 32'd9, 32'd3, 3'b000);
        check("u9_3.q", 64'(lo_o), 64'd3);
        check("u9_3.r", 64'(hi_o), 64'd0);

        run_div("midwr", 1'b0, 32'd12345, 32'd11, 3'b011);
        run_div("collide", 1'b0, 32'd50, 32'd8, 3'b100);
        check("collide.hi", 64'(hi_o), 64'd2);
        check("collide.lo", 64'(lo_o), 64'd6);

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) direct_write($urandom, $urandom);
            run_div($sformatf("rnd%0d", i), rs, ra, rb, 3'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
